// File: rtl/button_bcd_counter_if.sv
// Button, direction and clear inputs plus BCD digit and status outputs of the
// button-driven two-digit counter.
interface button_bcd_counter_if;
    logic       i_Switch;
    logic       i_Dir;
    logic       i_Clear;
    logic [3:0] o_Ones;
    logic [3:0] o_Tens;
    logic       o_Wrap;
    logic       o_Pressed;

    modport master (
        output i_Switch, i_Dir, i_Clear,
        input  o_Ones, o_Tens, o_Wrap, o_Pressed
    );

    modport slave (
        input  i_Switch, i_Dir, i_Clear,
        output o_Ones, o_Tens, o_Wrap, o_Pressed
    );
endinterface

// File: rtl/button_bcd_counter.sv
// Debounced push-button driving a two-digit BCD up/down counter (00-99)
// with a wrap pulse and a synchronous clear.
module button_bcd_counter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    button_bcd_counter_if.slave  bus
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_q1;
    logic             sync;
    logic             stable;
    logic [CNT_W-1:0] db_cnt;
    logic             count_pulse;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic             wrap;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q1 <= 1'b0;
            sync    <= 1'b0;
        end else begin
            sync_q1 <= bus.i_Switch;
            sync    <= sync_q1;
        end
    end

    // Any sample matching the current level restarts qualification; the count
    // pulse is raised on the same edge that accepts a rising level.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            stable      <= 1'b0;
            db_cnt      <= '0;
            count_pulse <= 1'b0;
        end else begin
            count_pulse <= 1'b0;
            if (sync == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                stable      <= sync;
                db_cnt      <= '0;
                count_pulse <= sync;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (bus.i_Clear) begin
                ones <= 4'd0;
                tens <= 4'd0;
            end else if (count_pulse) begin
                if (bus.i_Dir) begin
                    if (ones != 4'd9) begin
                        ones <= ones + 4'd1;
                    end else begin
                        ones <= 4'd0;
                        if (tens != 4'd9) begin
                            tens <= tens + 4'd1;
                        end else begin
                            tens <= 4'd0;
                            wrap <= 1'b1;
                        end
                    end
                end else begin
                    if (ones != 4'd0) begin
                        ones <= ones - 4'd1;
                    end else begin
                        ones <= 4'd9;
                        if (tens != 4'd0) begin
                            tens <= tens - 4'd1;
                        end else begin
                            tens <= 4'd9;
                            wrap <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.o_Ones    = ones;
    assign bus.o_Tens    = tens;
    assign bus.o_Wrap    = wrap;
    assign bus.o_Pressed = stable;
endmodule

// File: tb/tb_button_bcd_counter.sv
// Directed and random stimulus for button_bcd_counter (DEBOUNCE_LIMIT=4),
// checked every cycle against a sample-history reference model.
module tb_button_bcd_counter;
    localparam int L = 4;

    logic clk;
    logic rst_n;
    button_bcd_counter_if bus();

    button_bcd_counter #(.DEBOUNCE_LIMIT(L)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int wrap_seen;

    // Model: raw switch samples since reset, accepted level, pending count
    // event, and the counter as a plain integer 0..99.
    int rawq[$];
    bit m_stable;
    bit m_ev;
    int m_val;
    bit m_wrap;

    function automatic bit sample_at(int k);
        return (k >= 0) ? rawq[k][0] : 1'b0;
    endfunction

    task automatic model_reset();
        rawq.delete();
        m_stable = 1'b0;
        m_ev     = 1'b0;
        m_val    = 0;
        m_wrap   = 1'b0;
    endtask

    task automatic model_edge(input bit sw, input bit dir, input bit clr);
        int  n;
        bit  all_diff;
        m_wrap = 1'b0;
        if (clr) m_val = 0;
        else if (m_ev) begin
            if (dir) begin
                if (m_val == 99) begin m_val = 0; m_wrap = 1'b1; end
                else m_val = m_val + 1;
            end else begin
                if (m_val == 0) begin m_val = 99; m_wrap = 1'b1; end
                else m_val = m_val - 1;
            end
        end
        // The level seen by qualification at this edge is the switch from two
        // edges earlier; a change needs L such samples in a row.
        rawq.push_back(int'(sw));
        n = rawq.size();
        all_diff = 1'b1;
        for (int i = 0; i < L; i++)
            if (sample_at(n - 3 - i) == m_stable) all_diff = 1'b0;
        m_ev = 1'b0;
        if (all_diff) begin
            m_stable = ~m_stable;
            m_ev     = m_stable;
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic int dut_pack();
        return int'({bus.o_Tens, bus.o_Ones, bus.o_Wrap, bus.o_Pressed});
    endfunction

    function automatic int model_pack();
        logic [3:0] t, o;
        t = 4'(m_val / 10);
        o = 4'(m_val % 10);
        return int'({t, o, m_wrap, m_stable});
    endfunction

    function automatic int digits();
        return int'({bus.o_Tens, bus.o_Ones});
    endfunction

    task automatic step(input bit sw, input bit dir, input bit clr, input string tag);
        bus.i_Switch = sw;
        bus.i_Dir    = dir;
        bus.i_Clear  = clr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(sw, dir, clr);
        #1;
        if (bus.o_Wrap === 1'b1) wrap_seen++;
        chk(tag, dut_pack(), model_pack());
    endtask

    task automatic press(input bit dir);
        repeat (8) step(1'b1, dir, 1'b0, "press_hi");
        repeat (8) step(1'b0, dir, 1'b0, "press_lo");
    endtask

    task automatic clear_now();
        step(1'b0, 1'b1, 1'b1, "clear");
    endtask

    initial begin
        bit carry_done;
        bit sw;
        rst_n = 1'b0;
        bus.i_Switch = 1'b0;
        bus.i_Dir    = 1'b1;
        bus.i_Clear  = 1'b0;
        model_reset();
        #2;
        chk("reset_state", dut_pack(), 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, "in_reset");
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0, "idle");

        // Clean press: digit update on the 7th edge after the switch goes high
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b1, 1'b0, "clean_hi");
        chk("latency_pre", digits(), 'h00);
        step(1'b1, 1'b1, 1'b0, "clean_hi");
        chk("latency_hit", digits(), 'h01);
        chk("pressed", int'(bus.o_Pressed), 1);
        repeat (13) step(1'b1, 1'b1, 1'b0, "clean_hold");
        chk("single_event", digits(), 'h01);
        repeat (8) step(1'b0, 1'b1, 1'b0, "clean_lo");
        chk("released", int'(bus.o_Pressed), 0);

        // Bounce then hold
        step(1'b1, 1'b1, 1'b0, "bounce");
        step(1'b0, 1'b1, 1'b0, "bounce");
        step(1'b1, 1'b1, 1'b0, "bounce");
        step(1'b0, 1'b1, 1'b0, "bounce");
        repeat (10) step(1'b1, 1'b1, 1'b0, "bounce_hold");
        repeat (8)  step(1'b0, 1'b1, 1'b0, "bounce_lo");
        chk("bounce_one_inc", digits(), 'h02);

        // Preload to 99 with a decade-carry check, then wrap up
        carry_done = 1'b0;
        while (m_val != 99) begin
            press(1'b1);
            if (m_val == 10 && !carry_done) begin
                chk("carry_09_10", digits(), 'h10);
                carry_done = 1'b1;
            end
        end
        chk("preload_99", digits(), 'h99);
        wrap_seen = 0;
        press(1'b1);
        chk("up_wrap_digits", digits(), 'h00);
        chk("up_wrap_pulses", wrap_seen, 1);

        // Down wrap and borrow
        wrap_seen = 0;
        press(1'b0);
        chk("down_wrap_digits", digits(), 'h99);
        chk("down_wrap_pulses", wrap_seen, 1);
        wrap_seen = 0;
        press(1'b0);
        chk("down_98", digits(), 'h98);
        chk("no_wrap_98", wrap_seen, 0);
        clear_now();
        repeat (10) press(1'b1);
        press(1'b0);
        chk("borrow_10_09", digits(), 'h09);

        // Clear on the count-event cycle at 45
        clear_now();
        repeat (45) press(1'b1);
        chk("at_45", digits(), 'h45);
        repeat (6) step(1'b1, 1'b1, 1'b0, "cc_hi");
        step(1'b1, 1'b1, 1'b1, "cc_clear");
        chk("clear_vs_count", dut_pack(), int'({8'h00, 1'b0, 1'b1}));
        repeat (8) step(1'b0, 1'b1, 1'b0, "cc_lo");
        chk("clear_stays", digits(), 'h00);

        // Reset while holding at 37(+1), requalify after release
        repeat (37) press(1'b1);
        repeat (10) step(1'b1, 1'b1, 1'b0, "rp_hold");
        chk("rp_38", digits(), 'h38);
        rst_n = 1'b0;
        #1;
        chk("rst_async", dut_pack(), 0);
        model_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, "rp_in_reset");
        rst_n = 1'b1;
        repeat (10) step(1'b1, 1'b1, 1'b0, "rp_requal");
        chk("rst_requal", digits(), 'h01);
        repeat (8) step(1'b0, 1'b1, 1'b0, "rp_lo");

        // Random bouncy button, direction and occasional clear
        sw = 1'b0;
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) sw = ~sw;
            step(sw, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/button_bcd_counter.md
BUTTON_BCD_COUNTER -- requirements
Module: button_bcd_counter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000, giving the consecutive-sample count needed to accept a button level change (legal range 2..2^20-1).
REQ-002 i_Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 i_Rst_n  input  1  asynchronous active-low reset; release is synchronous to i_Clk.
REQ-004 i_Switch  input  1  raw, bouncy, asynchronous push-button level; active-high.
REQ-005 i_Dir  input  1  count direction, sampled on the count pulse: 1 = up, 0 = down.
REQ-006 i_Clear  input  1  synchronous clear to 00, active-high.
REQ-007 o_Ones  output  4  BCD ones digit, 0-9, drives the 7-segment decoder's binary input.
REQ-008 o_Tens  output  4  BCD tens digit, 0-9, drives a second 7-segment decoder.
REQ-009 o_Wrap  output  1  one-cycle pulse on 99->00 (up) or 00->99 (down).
REQ-010 o_Pressed  output  1  debounced button level.

Function
REQ-011 i_Switch SHALL pass through a two-flop synchronizer before any other use; the synchronizer output is called sync.
REQ-012 The debouncer SHALL hold a stable level and a counter sized for DEBOUNCE_LIMIT.
- If sync equals stable, the counter clears to 0.
- If sync differs from stable, the counter increments.
- When the counter equals DEBOUNCE_LIMIT-1 while sync differs, stable takes sync and the counter clears.
REQ-013 Any sync sample equal to stable before the limit SHALL restart qualification from 0 (glitch rejection).
REQ-014 o_Pressed SHALL equal stable.
REQ-015 A count event SHALL occur on the cycle after stable goes 0->1.
- It is a single-cycle internal pulse.
- No event on 1->0.
- No repeat while held.
REQ-016 On a count event with i_Dir=1, the counter SHALL increment:
- Ones 0-8: +1.
- Ones 9: ones=0, tens+1.
- Value 99: becomes 00 and o_Wrap=1 for that cycle.
REQ-017 On a count event with i_Dir=0, the counter SHALL decrement:
- Ones 1-9: -1.
- Ones 0: ones=9, tens-1.
- Value 00: becomes 99 and o_Wrap=1 for that cycle.
REQ-018 The digit outputs SHALL be registered and update on the same edge that consumes the count event; the digits never hold values 10-15.
REQ-019 i_Clear SHALL have priority over a simultaneous count event:
- Digits go to 00.
- o_Wrap stays 0.
- The debouncer state is unaffected.
REQ-020 o_Wrap SHALL be 0 in every cycle other than a wrap transition.
REQ-021 Latency SHALL be exactly 2 + DEBOUNCE_LIMIT + 1 clocks, from the first edge where i_Switch is sampled high (held clean) to the digit update.

Reset
REQ-022 While i_Rst_n=0, the following SHALL be 0 asynchronously:
- synchronizer flops
- stable
- debounce counter
- count pulse
- o_Ones, o_Tens, o_Wrap, o_Pressed
REQ-023 Reset asserted mid-qualification or mid-press SHALL discard progress. After release, a button still held high SHALL requalify and produce exactly one count event.

Verification (DEBOUNCE_LIMIT=4)
REQ-024 The bench SHALL cover the following directed scenarios:
- Clean press: from 00, i_Dir=1, i_Switch high for 20 clks -> digits 01 after 7 clks; single event; o_Pressed=1.
- Bounce: i_Switch toggles 1,0,1,0 each clk, then held high -> no update until 4 consecutive synced highs; exactly one increment.
- Up wrap: preload to 99 by 99 presses, then press with i_Dir=1 -> digits 00, o_Wrap high exactly 1 clk. Decade carry at 09->10 checked.
- Down wrap: from 00, press with i_Dir=0 -> 99 with o_Wrap pulse. Then press -> 98; at 10 press -> 09.
- Clear vs count: i_Clear asserted on the count-event cycle at 45 -> 00, o_Wrap=0.
- Reset mid-press: i_Rst_n low during hold at 37 -> all outputs 0 immediately. Release with button held -> 01 after requalification.
